// File: rtl/timing_chain_gen.sv
// timing_chain_gen: master-clock prescaler chain producing digit strobes,
// the one-hot PX digit bus, blackout / para-blackout waveforms and a one-hot
// beat sequence, with stop / single-shot run control that only ever acts at
// bar (or, when halted, beat 0) boundaries so digit scanning never pauses.
module timing_chain_gen #(
    parameter int WORD_LENGTH     = 20,
    parameter int BLACKOUT_DIGITS = 4,
    parameter int DIV             = 4,
    parameter int BEATS           = 4,
    parameter int DW              = $clog2(WORD_LENGTH + BLACKOUT_DIGITS)
) (
    input  logic                   w_CLK,
    input  logic                   w_RST,
    input  logic                   w_STOP,
    input  logic                   w_SINGLE,
    output logic                   w_DIGIT_TICK,
    output logic [DW-1:0]          b_DIGIT,
    output logic [WORD_LENGTH-1:0] b_PX,
    output logic                   w_BO_WF,
    output logic                   w_PARA_BO_WF,
    output logic [BEATS-1:0]       b_BEAT,
    output logic                   w_BAR_END,
    output logic                   w_HALTED
);

    localparam int DIGITS = WORD_LENGTH + BLACKOUT_DIGITS;
    localparam int DIVW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW     = $clog2(BEATS);

    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(DIV - 1);
    localparam logic [DIVW-1:0] DIV_ONE   = DIVW'(1);
    localparam logic [DW-1:0]   DIG_LAST  = DW'(DIGITS - 1);
    localparam logic [DW-1:0]   DIG_ONE   = DW'(1);
    localparam logic [DW-1:0]   DIG_BO    = DW'(WORD_LENGTH);
    localparam logic [BW-1:0]   BEAT_LAST = BW'(BEATS - 1);
    localparam logic [BW-1:0]   BEAT_ONE  = BW'(1);

    // Run-control states
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_STOPPED = 2'd1;
    localparam logic [1:0] ST_SINGLE  = 2'd2;

    logic [DIVW-1:0] r_divCnt;
    logic [DW-1:0]   r_digCnt;
    logic [BW-1:0]   r_beatCnt;
    logic [1:0]      r_state;
    logic            r_pend;
    logic            r_singleDly;

    logic                   r_digitTick;
    logic [DW-1:0]          r_digit;
    logic [WORD_LENGTH-1:0] r_px;
    logic                   r_bo;
    logic                   r_paraBo;
    logic [BEATS-1:0]       r_beat;
    logic                   r_barEnd;
    logic                   r_halted;

    logic                   w_digitEnd;
    logic                   w_beatEnd;
    logic                   w_barEnd;
    logic                   w_singleRise;
    logic                   w_pendNow;
    logic                   w_boNext;
    logic [WORD_LENGTH-1:0] w_pxNext;
    logic [BEATS-1:0]       w_beatNext;

    assign w_digitEnd   = (r_divCnt == DIV_LAST);
    assign w_beatEnd    = w_digitEnd && (r_digCnt == DIG_LAST);
    assign w_barEnd     = w_beatEnd && (r_beatCnt == BEAT_LAST);
    assign w_singleRise = w_SINGLE && !r_singleDly;
    // A single-shot request only latches while halted; in RUN/SINGLE it is dropped.
    assign w_pendNow    = r_pend || ((r_state == ST_STOPPED) && w_singleRise);
    assign w_boNext     = (r_digCnt >= DIG_BO);

    // One-hot decodes of the digit and beat counters (PX is all zero in blackout)
    always_comb begin
        w_pxNext   = '0;
        w_beatNext = '0;
        for (int i = 0; i < WORD_LENGTH; i++) begin
            w_pxNext[i] = (r_digCnt == DW'(i));
        end
        for (int j = 0; j < BEATS; j++) begin
            w_beatNext[j] = (r_beatCnt == BW'(j));
        end
    end

    // Prescaler and digit counters free-run regardless of run control
    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            r_divCnt <= '0;
            r_digCnt <= '0;
        end else begin
            r_divCnt <= w_digitEnd ? '0 : (r_divCnt + DIV_ONE);
            if (w_digitEnd) begin
                r_digCnt <= (r_digCnt == DIG_LAST) ? '0 : (r_digCnt + DIG_ONE);
            end
        end
    end

    // Beat counter and run-control FSM; decisions only at beat ends
    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            r_beatCnt   <= '0;
            r_state     <= ST_RUN;
            r_pend      <= 1'b0;
            r_singleDly <= 1'b0;
        end else begin
            r_singleDly <= w_SINGLE;
            r_pend      <= w_pendNow;
            if (w_beatEnd) begin
                case (r_state)
                    ST_RUN: begin
                        if (r_beatCnt == BEAT_LAST) begin
                            r_beatCnt <= '0;
                            if (w_STOP) begin
                                r_state <= ST_STOPPED;
                            end
                        end else begin
                            r_beatCnt <= r_beatCnt + BEAT_ONE;
                        end
                    end
                    ST_STOPPED: begin
                        if (w_pendNow) begin
                            r_pend    <= 1'b0;
                            r_state   <= ST_SINGLE;
                            r_beatCnt <= BEAT_ONE;
                        end else if (!w_STOP) begin
                            r_state   <= ST_RUN;
                            r_beatCnt <= BEAT_ONE;
                        end else begin
                            r_beatCnt <= '0;
                        end
                    end
                    ST_SINGLE: begin
                        if (r_beatCnt == BEAT_LAST) begin
                            r_beatCnt <= '0;
                            r_state   <= ST_STOPPED;
                        end else begin
                            r_beatCnt <= r_beatCnt + BEAT_ONE;
                        end
                    end
                    default: begin
                        r_beatCnt <= '0;
                        r_state   <= ST_RUN;
                    end
                endcase
            end
        end
    end

    // Registered output decodes, one cycle behind the counters
    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            r_digitTick <= 1'b0;
            r_digit     <= '0;
            r_px        <= '0;
            r_bo        <= 1'b1;
            r_paraBo    <= 1'b0;
            r_beat      <= '0;
            r_barEnd    <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_digitTick <= w_digitEnd;
            r_digit     <= r_digCnt;
            r_px        <= w_pxNext;
            r_bo        <= w_boNext;
            r_paraBo    <= !w_boNext;
            r_beat      <= w_beatNext;
            r_barEnd    <= w_barEnd && (r_state != ST_STOPPED);
            r_halted    <= (r_state == ST_STOPPED);
        end
    end

    assign w_DIGIT_TICK = r_digitTick;
    assign b_DIGIT      = r_digit;
    assign b_PX         = r_px;
    assign w_BO_WF      = r_bo;
    assign w_PARA_BO_WF = r_paraBo;
    assign b_BEAT       = r_beat;
    assign w_BAR_END    = r_barEnd;
    assign w_HALTED     = r_halted;

endmodule
